mem_port_arbiter: RTL and testbench
===================================

Name: mem_port_arbiter

Overview:
- Shares one single-ported unified memory between the IF stage (instruction fetch, read-only) and the MEM stage (load/store).
- Sequences each access with a req/ack handshake to a memory of variable latency.
- Produces the per-stage stall signals that the pipeline hazard logic ORs into its freeze and flush path.
- Sits between the pipeline stage registers and the memory model.

Parameters:
ADDR_W, 32, address width
DATA_W, 32, data width; byte enables are DATA_W/8 wide
TIMEOUT_CYC, 255, max cycles waiting for mem_ack; used only when the optional feature is compiled in

Ports:
clock  in  1  system clock, rising edge
reset  in  1  asynchronous, active-low reset
w_if_req  in  1  fetch request; held until w_if_done
w_if_addr  in  ADDR_W  fetch address
w_if_rdata  out  DATA_W  fetched instruction
w_if_done  out  1  one-cycle fetch completion
w_if_stall  out  1  freeze IF/PC
w_d_req  in  1  data request; held until w_d_done
w_d_we  in  1  1 = store, 0 = load
w_d_be  in  DATA_W/8  store byte enables
w_d_addr  in  ADDR_W  data address
w_d_wdata  in  DATA_W  store data
w_d_rdata  out  DATA_W  load data
w_d_done  out  1  one-cycle data completion
w_mem_stall  out  1  freeze MEM and all older stages
w_mreq  out  1  memory request, held until ack
w_mwe  out  1  memory write enable
w_mbe  out  DATA_W/8  memory byte enables
w_maddr  out  ADDR_W  memory address
w_mwdata  out  DATA_W  memory write data
w_mack  in  1  memory ack; read data valid in the same cycle
w_mrdata  in  DATA_W  memory read data
w_bus_err  out  1  sticky timeout flag; tied 0 without the optional feature

Behaviour:
- FSM states: IDLE, D_WAIT, F_WAIT, D_RESP, F_RESP. State is registered.
- Reset values: state=IDLE. All outputs 0: w_mreq, w_mwe, w_mbe, w_maddr, w_mwdata, w_if_rdata, w_d_rdata, w_if_done, w_d_done, w_bus_err.
- Reset mid-transaction: w_mreq drops immediately (async). Any in-flight access is abandoned. A late w_mack after reset is ignored because the FSM is in IDLE.
- IDLE:
  - w_d_req wins over w_if_req. MEM is the older instruction, so giving it priority prevents deadlock.
  - On a grant, latch addr/we/be/wdata into the w_m* registers, set w_mreq=1, and go to D_WAIT or F_WAIT.
  - A fetch-only request goes to F_WAIT with w_mwe=0 and w_mbe all-ones.
- D_WAIT / F_WAIT:
  - w_m* outputs stay stable; requester input changes are ignored.
  - On w_mack: w_mreq<=0. Capture w_mrdata into w_d_rdata (loads only) or w_if_rdata. Go to D_RESP / F_RESP.
  - Store completions leave w_d_rdata unchanged.
- D_RESP / F_RESP:
  - Assert w_d_done / w_if_done for exactly this cycle, then go to IDLE.
  - No arbitration in this cycle, so a requester that still holds req while advancing is never re-issued.
- Stalls (combinational from registered state):
  - w_mem_stall = w_d_req & ~w_d_done.
  - w_if_stall = w_if_req & ~w_if_done.
- Timing:
  - Minimum latency, request to done: 3 cycles (grant edge, ack with 0-wait memory, resp).
  - Back-to-back accesses have one IDLE cycle between them.
- Simultaneous requests: data is served first. Fetch is served on the next IDLE.
- Starvation: fetch starvation is not possible. w_mem_stall freezes older stages, and the MEM request clears once it completes.
- w_mack outside a WAIT state: ignored.
- Requester dropping req while in a WAIT state: the access still completes, and the done pulse is still produced.

Optional Feature:
MEM_TIMEOUT_EN:
- Defined:
  - An 8-bit-minimum counter clears on entering a WAIT state and increments each WAIT cycle.
  - On reaching TIMEOUT_CYC without w_mack: drop w_mreq, set w_bus_err (sticky until reset), load rdata=0, go to the matching RESP state. Done is produced normally, so the pipeline never hangs.
- Undefined:
  - No counter is built, and w_bus_err is tied 0.
  - WAIT states persist indefinitely until w_mack.

Decomposition:
- Shared package (mem_arb_pkg):
  - State enum encodings ST_IDLE, ST_D_WAIT, ST_F_WAIT, ST_D_RESP, ST_F_RESP.
  - Default ADDR_W/DATA_W constants.
  - BE_ALL constant.
- Sub-module mem_req_latch: the registered w_m* request holding register with load/clear. All remaining logic (FSM, stall, timeout) stays in the top.

Test Plan:
- Fetch only, addr=0x40, w_mack 2 cycles after w_mreq with rdata=0x8C220004 -> w_if_done 1 cycle after ack, w_if_rdata=0x8C220004, w_if_stall high until the done cycle.
- w_if_req and w_d_req (load 0x100) rise in the same cycle -> w_maddr=0x100 first, w_if_stall held throughout, fetch issued after D_RESP+IDLE.
- Store addr=0x200, be=4'b0011, wdata=0xDEADBEEF -> w_mwe=1, w_mbe=0011, w_mwdata=0xDEADBEEF, w_d_rdata unchanged, w_d_done single pulse.
- reset asserted low during F_WAIT -> w_mreq=0 immediately, state IDLE; a later w_mack produces no done.
- MEM_TIMEOUT_EN, TIMEOUT_CYC=4, no ack -> w_bus_err=1 after 4 WAIT cycles, w_d_rdata=0, w_d_done pulse, w_bus_err stays 1.

Source files
------------

// File: rtl/mem_arb_pkg.sv
// Shared types and constants for the IF/MEM unified memory port arbiter.
package mem_arb_pkg;

  localparam int ADDR_W_DEF = 32;
  localparam int DATA_W_DEF = 32;
  localparam logic [DATA_W_DEF/8-1:0] BE_ALL = '1;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_D_WAIT,
    ST_F_WAIT,
    ST_D_RESP,
    ST_F_RESP
  } arb_state_e;

endpackage

// File: rtl/mem_port_arbiter_if.sv
// Requester and memory-side signals of the memory port arbiter.
interface mem_port_arbiter_if
  import mem_arb_pkg::*;
#(
  parameter int ADDR_W = ADDR_W_DEF,
  parameter int DATA_W = DATA_W_DEF
);
  logic              w_if_req;
  logic [ADDR_W-1:0] w_if_addr;
  logic [DATA_W-1:0] w_if_rdata;
  logic              w_if_done;
  logic              w_if_stall;

  logic                w_d_req;
  logic                w_d_we;
  logic [DATA_W/8-1:0] w_d_be;
  logic [ADDR_W-1:0]   w_d_addr;
  logic [DATA_W-1:0]   w_d_wdata;
  logic [DATA_W-1:0]   w_d_rdata;
  logic                w_d_done;
  logic                w_mem_stall;

  logic                w_mreq;
  logic                w_mwe;
  logic [DATA_W/8-1:0] w_mbe;
  logic [ADDR_W-1:0]   w_maddr;
  logic [DATA_W-1:0]   w_mwdata;
  logic                w_mack;
  logic [DATA_W-1:0]   w_mrdata;
  logic                w_bus_err;

  modport slave (
    input  w_if_req, w_if_addr,
    input  w_d_req, w_d_we, w_d_be, w_d_addr, w_d_wdata,
    input  w_mack, w_mrdata,
    output w_if_rdata, w_if_done, w_if_stall,
    output w_d_rdata, w_d_done, w_mem_stall,
    output w_mreq, w_mwe, w_mbe, w_maddr, w_mwdata,
    output w_bus_err
  );

  modport master (
    output w_if_req, w_if_addr,
    output w_d_req, w_d_we, w_d_be, w_d_addr, w_d_wdata,
    output w_mack, w_mrdata,
    input  w_if_rdata, w_if_done, w_if_stall,
    input  w_d_rdata, w_d_done, w_mem_stall,
    input  w_mreq, w_mwe, w_mbe, w_maddr, w_mwdata,
    input  w_bus_err
  );

endinterface

// File: rtl/mem_req_latch.sv
// Holding register for the outstanding memory request (w_m* bus).
module mem_req_latch #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                load_i,
  input  logic                clr_i,
  input  logic                we_i,
  input  logic [DATA_W/8-1:0] be_i,
  input  logic [ADDR_W-1:0]   addr_i,
  input  logic [DATA_W-1:0]   wdata_i,
  output logic                mreq_o,
  output logic                mwe_o,
  output logic [DATA_W/8-1:0] mbe_o,
  output logic [ADDR_W-1:0]   maddr_o,
  output logic [DATA_W-1:0]   mwdata_o
);
  logic                mreq_q;
  logic                mwe_q;
  logic [DATA_W/8-1:0] mbe_q;
  logic [ADDR_W-1:0]   maddr_q;
  logic [DATA_W-1:0]   mwdata_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mreq_q   <= 1'b0;
      mwe_q    <= 1'b0;
      mbe_q    <= '0;
      maddr_q  <= '0;
      mwdata_q <= '0;
    end else if (load_i) begin
      mreq_q   <= 1'b1;
      mwe_q    <= we_i;
      mbe_q    <= be_i;
      maddr_q  <= addr_i;
      mwdata_q <= wdata_i;
    end else if (clr_i) begin
      mreq_q   <= 1'b0;
    end
  end

  assign mreq_o   = mreq_q;
  assign mwe_o    = mwe_q;
  assign mbe_o    = mbe_q;
  assign maddr_o  = maddr_q;
  assign mwdata_o = mwdata_q;

endmodule

// File: rtl/mem_port_arbiter.sv
// IF/MEM arbiter for a single-ported unified memory with req/ack handshake.
// Optional wait timeout with sticky bus error: define MEM_TIMEOUT_EN.
module mem_port_arbiter
  import mem_arb_pkg::*;
#(
  parameter int ADDR_W      = ADDR_W_DEF,
  parameter int DATA_W      = DATA_W_DEF,
  parameter int TIMEOUT_CYC = 255
) (
  input logic               clock,
  input logic               reset,
  mem_port_arbiter_if.slave bus
);
  localparam int BE_W = DATA_W / 8;

  arb_state_e        state_q;
  logic [DATA_W-1:0] if_rdata_q;
  logic [DATA_W-1:0] d_rdata_q;
  logic              if_done_q;
  logic              d_done_q;

  logic              grant;
  logic              in_wait;
  logic              tmo;
  logic              fin;
  logic              mwe;
  logic [BE_W-1:0]   ld_be;
  logic [ADDR_W-1:0] ld_addr;
  logic [DATA_W-1:0] ld_wdata;

  assign in_wait = (state_q == ST_D_WAIT) || (state_q == ST_F_WAIT);
  assign grant   = (state_q == ST_IDLE) && (bus.w_d_req || bus.w_if_req);
  assign fin     = in_wait && (bus.w_mack || tmo);

  // MEM is the older instruction, so it wins the port
  assign ld_be    = bus.w_d_req ? bus.w_d_be : {BE_W{BE_ALL[0]}};
  assign ld_addr  = bus.w_d_req ? bus.w_d_addr : bus.w_if_addr;
  assign ld_wdata = bus.w_d_req ? bus.w_d_wdata : '0;

  mem_req_latch #(
    .ADDR_W (ADDR_W),
    .DATA_W (DATA_W)
  ) u_req (
    .clk      (clock),
    .rst_n    (reset),
    .load_i   (grant),
    .clr_i    (fin),
    .we_i     (bus.w_d_req & bus.w_d_we),
    .be_i     (ld_be),
    .addr_i   (ld_addr),
    .wdata_i  (ld_wdata),
    .mreq_o   (bus.w_mreq),
    .mwe_o    (mwe),
    .mbe_o    (bus.w_mbe),
    .maddr_o  (bus.w_maddr),
    .mwdata_o (bus.w_mwdata)
  );

`ifdef MEM_TIMEOUT_EN
  localparam int CLG   = $clog2(TIMEOUT_CYC + 1);
  localparam int CNT_W = (CLG > 8) ? CLG : 8;

  logic [CNT_W-1:0] cnt_q;
  logic             bus_err_q;

  assign tmo = in_wait && !bus.w_mack &&
               (cnt_q == CNT_W'(TIMEOUT_CYC - 1));

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      cnt_q     <= '0;
      bus_err_q <= 1'b0;
    end else begin
      if (grant)
        cnt_q <= '0;
      else if (in_wait)
        cnt_q <= cnt_q + 1'b1;
      if (tmo)
        bus_err_q <= 1'b1;
    end
  end

  assign bus.w_bus_err = bus_err_q;
`else
  logic unused_tmo;
  assign unused_tmo    = (TIMEOUT_CYC == 0);
  assign tmo           = 1'b0;
  assign bus.w_bus_err = 1'b0;
`endif

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q    <= ST_IDLE;
      if_rdata_q <= '0;
      d_rdata_q  <= '0;
      if_done_q  <= 1'b0;
      d_done_q   <= 1'b0;
    end else begin
      if_done_q <= 1'b0;
      d_done_q  <= 1'b0;
      unique case (state_q)
        ST_IDLE: begin
          if (bus.w_d_req)
            state_q <= ST_D_WAIT;
          else if (bus.w_if_req)
            state_q <= ST_F_WAIT;
        end
        ST_D_WAIT: begin
          if (fin) begin
            state_q  <= ST_D_RESP;
            d_done_q <= 1'b1;
            if (!mwe)
              d_rdata_q <= tmo ? '0 : bus.w_mrdata;
          end
        end
        ST_F_WAIT: begin
          if (fin) begin
            state_q    <= ST_F_RESP;
            if_done_q  <= 1'b1;
            if_rdata_q <= tmo ? '0 : bus.w_mrdata;
          end
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  assign bus.w_mwe       = mwe;
  assign bus.w_if_rdata  = if_rdata_q;
  assign bus.w_d_rdata   = d_rdata_q;
  assign bus.w_if_done   = if_done_q;
  assign bus.w_d_done    = d_done_q;
  assign bus.w_if_stall  = bus.w_if_req & ~if_done_q;
  assign bus.w_mem_stall = bus.w_d_req & ~d_done_q;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed plus random bench for mem_port_arbiter against a memory model.
module tb_mem_port_arbiter;
  import mem_arb_pkg::*;

  localparam int TO = 4;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  mem_port_arbiter_if bus ();

  mem_port_arbiter #(
    .ADDR_W      (32),
    .DATA_W      (32),
    .TIMEOUT_CYC (TO)
  ) dut (
    .clock (clk),
    .reset (rst_n),
    .bus   (bus)
  );

  typedef struct packed {
    logic        we;
    logic [3:0]  be;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [3:0]  lat;
  } acc_t;

  int ncmp = 0;
  int nfail = 0;

  logic [31:0] mem     [256];
  logic [31:0] ref_mem [256];
  logic [31:0] exp_d_rdata = '0;
  logic [31:0] exp_if_rdata = '0;
  acc_t        acc_q [$];

  bit          mem_hold = 1'b0;
  int          force_lat = -1;
  int          wcnt = 0;
  int          cur_lat = 0;
  logic        resp_ack = 1'b0;
  logic        man_ack = 1'b0;
  logic [31:0] resp_data = '0;

  assign bus.w_mack   = resp_ack | man_ack;
  assign bus.w_mrdata = resp_data;

  // Variable-latency memory: acks after cur_lat extra wait cycles
  always @(negedge clk) begin
    resp_ack  = 1'b0;
    resp_data = $urandom;
    if (!mem_hold) begin
      if (rst_n && bus.w_mreq) begin
        if (wcnt == 0)
          cur_lat = (force_lat >= 0) ? force_lat : $urandom_range(0, 3);
        if (wcnt == cur_lat) begin
          resp_ack = 1'b1;
          acc_q.push_back({bus.w_mwe, bus.w_mbe, bus.w_maddr,
                           bus.w_mwdata, 4'(cur_lat)});
          if (bus.w_mwe) begin
            for (int b = 0; b < 4; b++)
              if (bus.w_mbe[b])
                mem[bus.w_maddr[9:2]][8*b +: 8] = bus.w_mwdata[8*b +: 8];
          end else begin
            resp_data = mem[bus.w_maddr[9:2]];
          end
          wcnt = 0;
        end else begin
          wcnt++;
        end
      end else begin
        wcnt = 0;
      end
    end
  end

  task automatic chk(input string tag, input logic [63:0] obs,
                     input logic [63:0] exp);
    ncmp++;
    assert (obs === exp) else begin
      nfail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] rnd_addr();
    return {22'd0, 8'($urandom_range(0, 255)), 2'b00};
  endfunction

  // One arbitration episode; caller is at #1 after an edge, arbiter IDLE
  task automatic xfer(input bit do_f, input logic [31:0] faddr,
                      input bit do_d, input bit we, input logic [3:0] be,
                      input logic [31:0] daddr, input logic [31:0] wdata,
                      input bit drop, input string tag);
    logic [31:0] exp_d;
    logic [31:0] exp_f;
    bit   f_fin;
    bit   d_fin;
    int   cyc;
    int   d_cyc;
    int   f_cyc;
    int   n;
    acc_t a;
    f_fin = !do_f;
    d_fin = !do_d;
    cyc = 0;
    d_cyc = 0;
    f_cyc = 0;
    exp_d = exp_d_rdata;
    exp_f = exp_if_rdata;
    if (do_d) begin
      if (we) begin
        for (int b = 0; b < 4; b++)
          if (be[b]) ref_mem[daddr[9:2]][8*b +: 8] = wdata[8*b +: 8];
      end else begin
        exp_d = ref_mem[daddr[9:2]];
      end
    end
    if (do_f) exp_f = ref_mem[faddr[9:2]];
    acc_q.delete();
    bus.w_if_req  = do_f;
    bus.w_if_addr = faddr;
    bus.w_d_req   = do_d;
    bus.w_d_we    = we;
    bus.w_d_be    = be;
    bus.w_d_addr  = daddr;
    bus.w_d_wdata = wdata;
    while (!(f_fin && d_fin) && cyc < 40) begin
      @(posedge clk);
      #1;
      cyc++;
      if (drop && cyc == 1) begin
        bus.w_if_req  = 1'b0;
        bus.w_d_req   = 1'b0;
        bus.w_if_addr = $urandom;
        bus.w_d_addr  = $urandom;
        bus.w_d_wdata = $urandom;
        bus.w_d_we    = ~we;
        #1;
      end
      if (!d_fin) begin
        if (bus.w_d_done === 1'b1) begin
          d_fin = 1'b1;
          d_cyc = cyc;
          chk({tag, "_drdata"}, bus.w_d_rdata, exp_d);
          chk({tag, "_dstall_done"}, bus.w_mem_stall, 0);
          bus.w_d_req = 1'b0;
        end else begin
          chk({tag, "_dstall"}, bus.w_mem_stall, bus.w_d_req);
        end
      end else begin
        chk({tag, "_dpulse"}, bus.w_d_done, 0);
      end
      if (!f_fin) begin
        if (bus.w_if_done === 1'b1) begin
          f_fin = 1'b1;
          f_cyc = cyc;
          chk({tag, "_frdata"}, bus.w_if_rdata, exp_f);
          chk({tag, "_fstall_done"}, bus.w_if_stall, 0);
          bus.w_if_req = 1'b0;
        end else begin
          chk({tag, "_fstall"}, bus.w_if_stall, bus.w_if_req);
        end
      end else begin
        chk({tag, "_fpulse"}, bus.w_if_done, 0);
      end
    end
    chk({tag, "_complete"}, {62'd0, f_fin, d_fin}, 3);
    @(posedge clk);
    #1;
    chk({tag, "_gap_done"}, {bus.w_d_done, bus.w_if_done}, 0);
    chk({tag, "_gap_mreq"}, bus.w_mreq, 0);
    n = int'(do_f) + int'(do_d);
    chk({tag, "_naccess"}, acc_q.size(), n);
    if (acc_q.size() == n) begin
      if (do_d) begin
        a = acc_q[0];
        chk({tag, "_d_addr"}, a.addr, daddr);
        chk({tag, "_d_we"}, a.we, we);
        chk({tag, "_d_be"}, a.be, be);
        if (we) chk({tag, "_d_wdata"}, a.wdata, wdata);
        chk({tag, "_d_lat"}, d_cyc, a.lat + 2);
      end
      if (do_f) begin
        a = acc_q[n-1];
        chk({tag, "_f_addr"}, a.addr, faddr);
        chk({tag, "_f_we"}, a.we, 0);
        chk({tag, "_f_be"}, a.be, BE_ALL);
        chk({tag, "_f_lat"}, f_cyc,
            (do_d ? d_cyc + 1 : 0) + a.lat + 2);
      end
    end
    exp_d_rdata  = exp_d;
    exp_if_rdata = exp_f;
  endtask

  int          kind;
  bit          drop;
  int          cyc;
  logic [31:0] tmp_addr;

  initial begin
    bus.w_if_req  = 1'b0;
    bus.w_if_addr = '0;
    bus.w_d_req   = 1'b0;
    bus.w_d_we    = 1'b0;
    bus.w_d_be    = '0;
    bus.w_d_addr  = '0;
    bus.w_d_wdata = '0;
    for (int i = 0; i < 256; i++) begin
      mem[i]     = $urandom;
      ref_mem[i] = mem[i];
    end
    mem[16]     = 32'h8C220004;
    ref_mem[16] = 32'h8C220004;

    repeat (3) @(posedge clk);
    #1;
    chk("rst_mreq", bus.w_mreq, 0);
    chk("rst_mwe", bus.w_mwe, 0);
    chk("rst_mbe", bus.w_mbe, 0);
    chk("rst_maddr", bus.w_maddr, 0);
    chk("rst_mwdata", bus.w_mwdata, 0);
    chk("rst_ifrdata", bus.w_if_rdata, 0);
    chk("rst_drdata", bus.w_d_rdata, 0);
    chk("rst_dones", {bus.w_if_done, bus.w_d_done}, 0);
    chk("rst_buserr", bus.w_bus_err, 0);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    force_lat = 2;
    xfer(1, 32'h40, 0, 0, 4'h0, 32'h0, 32'h0, 0, "fetch40");
    force_lat = -1;
    xfer(1, 32'h44, 1, 0, 4'hF, 32'h100, 32'h0, 0, "both");
    xfer(0, 32'h0, 1, 1, 4'b0011, 32'h200, 32'hDEADBEEF, 0, "store");
    xfer(0, 32'h0, 1, 0, 4'hF, 32'h200, 32'h0, 0, "ldback");
    force_lat = 0;
    xfer(1, 32'h48, 0, 0, 4'h0, 32'h0, 32'h0, 0, "fetch_l0");
    force_lat = -1;
    xfer(0, 32'h0, 1, 0, 4'hF, 32'h30, 32'h0, 1, "ld_drop");

    for (int it = 0; it < 40; it++) begin
      kind = $urandom_range(0, 2);
      drop = (kind != 2) && ($urandom_range(0, 3) == 0);
      tmp_addr = rnd_addr();
      xfer(kind != 1, tmp_addr, kind != 0, 1'($urandom_range(0, 1)),
           4'($urandom_range(1, 15)), rnd_addr(), $urandom, drop, "rnd");
    end

    // Reset while a fetch is waiting for an ack that never comes
    mem_hold = 1'b1;
    bus.w_if_req  = 1'b1;
    bus.w_if_addr = 32'h80;
    @(posedge clk);
    #1;
    chk("rstmid_mreq_pre", bus.w_mreq, 1);
    chk("rstmid_maddr_pre", bus.w_maddr, 32'h80);
    @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    chk("rstmid_mreq", bus.w_mreq, 0);
    chk("rstmid_maddr", bus.w_maddr, 0);
    chk("rstmid_ifrdata", bus.w_if_rdata, 0);
    bus.w_if_req = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    man_ack = 1'b1;
    @(posedge clk);
    #1;
    chk("late_ack_done0", {bus.w_if_done, bus.w_d_done}, 0);
    @(negedge clk);
    man_ack = 1'b0;
    @(posedge clk);
    #1;
    chk("late_ack_done1", {bus.w_if_done, bus.w_d_done}, 0);
    chk("late_ack_mreq", bus.w_mreq, 0);
    mem_hold = 1'b0;
    exp_d_rdata  = '0;
    exp_if_rdata = '0;
    xfer(1, 32'h80, 0, 0, 4'h0, 32'h0, 32'h0, 0, "post_rst");

`ifdef MEM_TIMEOUT_EN
    mem_hold = 1'b1;
    bus.w_d_req  = 1'b1;
    bus.w_d_we   = 1'b0;
    bus.w_d_be   = 4'hF;
    bus.w_d_addr = 32'h10;
    cyc = 0;
    while (bus.w_d_done !== 1'b1 && cyc < 20) begin
      @(posedge clk);
      #1;
      cyc++;
    end
    chk("to_cycles", cyc, TO + 1);
    chk("to_buserr", bus.w_bus_err, 1);
    chk("to_drdata", bus.w_d_rdata, 0);
    chk("to_mreq", bus.w_mreq, 0);
    bus.w_d_req = 1'b0;
    @(posedge clk);
    #1;
    chk("to_pulse", bus.w_d_done, 0);
    chk("to_sticky", bus.w_bus_err, 1);
    mem_hold = 1'b0;
    exp_d_rdata = '0;
    xfer(1, 32'h44, 0, 0, 4'h0, 32'h0, 32'h0, 0, "post_to");
    chk("to_sticky2", bus.w_bus_err, 1);
`else
    chk("buserr_tied", bus.w_bus_err, 0);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nfail);
    $finish;
  end

endmodule
